id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_pkg.sv | 84 ++++++++
 rtl/id_stage_if.sv | 45 ++++
 rtl/id_stage_reg_file.sv | 35 +++
 rtl/id_stage.sv | 116 +++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// id_pkg: constants and decode helper shared by the ID stage and the EX stage.
//   - opcode / funct encodings of the supported MIPS subset
//   - alu_op_t: ALU operation select carried down the pipe
//   - ctrl_t:   decoded control bundle plus operand-usage and branch flags
//   - decode(): instruction word -> ctrl_t (unsupported encodings give all zeros)
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef struct packed {
    logic [4:0] dest;
    alu_op_t    alu_op;
    logic       alu_imm;
    logic       mem_rd;
    logic       mem_wr;
    logic       wb;
    logic       use_rs;
    logic       use_rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADD:  begin c.alu_op = ALU_ADD; c.wb = 1'b1; end
          FN_SUB:  begin c.alu_op = ALU_SUB; c.wb = 1'b1; end
          FN_AND:  begin c.alu_op = ALU_AND; c.wb = 1'b1; end
          FN_OR:   begin c.alu_op = ALU_OR;  c.wb = 1'b1; end
          FN_SLT:  begin c.alu_op = ALU_SLT; c.wb = 1'b1; end
          default: c.wb = 1'b0;
        endcase
        // An unknown funct leaves c.wb low and the whole bundle stays a NOP.
        if (c.wb) begin
          c.dest   = instr[15:11];
          c.use_rs = 1'b1;
          c.use_rt = 1'b1;
        end
      end
      OP_ADDI: begin
        c.dest = instr[20:16]; c.alu_imm = 1'b1; c.wb = 1'b1; c.use_rs = 1'b1;
      end
      OP_LW: begin
        c.dest = instr[20:16]; c.alu_imm = 1'b1; c.mem_rd = 1'b1; c.wb = 1'b1;
        c.use_rs = 1'b1;
      end
      OP_SW: begin
        c.alu_imm = 1'b1; c.mem_wr = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1;
      end
      OP_BEQ: begin c.is_beq = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; end
      OP_BNE: begin c.is_bne = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; end
      OP_J:   c.is_j = 1'b1;
      default: c = '0;
    endcase
    // Writes to r0 are architecturally dead, so they never request writeback.
    if (c.dest == 5'd0) c.wb = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: all non-clock/reset signals of the decode stage.
//   inputs : pc_inc_in, instr_in (fetch), wb_en/wb_dest/wb_data (writeback),
//            haz_ex_wb/haz_ex_dest, haz_mem_wb/haz_mem_dest (hazard sources)
//   outputs: freeze, br_taken, br_addr (to fetch), idex_* (ID/EX register)
// master = the ID stage itself, slave = the surrounding pipeline.
interface id_stage_if;
  logic [31:0] pc_inc_in;
  logic [31:0] instr_in;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        haz_ex_wb;
  logic [4:0]  haz_ex_dest;
  logic        haz_mem_wb;
  logic [4:0]  haz_mem_dest;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_addr;
  logic [31:0] idex_pc_inc;
  logic [31:0] idex_val1;
  logic [31:0] idex_val2;
  logic [31:0] idex_imm;
  logic [4:0]  idex_dest;
  logic [2:0]  idex_alu_op;
  logic        idex_alu_imm;
  logic        idex_mem_rd;
  logic        idex_mem_wr;
  logic        idex_wb;

  modport master (
    input  pc_inc_in, instr_in, wb_en, wb_dest, wb_data,
           haz_ex_wb, haz_ex_dest, haz_mem_wb, haz_mem_dest,
    output freeze, br_taken, br_addr,
           idex_pc_inc, idex_val1, idex_val2, idex_imm,
           idex_dest, idex_alu_op, idex_alu_imm, idex_mem_rd, idex_mem_wr, idex_wb
  );

  modport slave (
    output pc_inc_in, instr_in, wb_en, wb_dest, wb_data,
           haz_ex_wb, haz_ex_dest, haz_mem_wb, haz_mem_dest,
    input  freeze, br_taken, br_addr,
           idex_pc_inc, idex_val1, idex_val2, idex_imm,
           idex_dest, idex_alu_op, idex_alu_imm, idex_mem_rd, idex_mem_wr, idex_wb
  );
endinterface

// File: rtl/id_stage_reg_file.sv
// reg_file: 32 x 32-bit register file.
//   clk, rst      : clock, async active-high reset (clears every register)
//   ra1/ra2 -> rd1/rd2 : asynchronous read ports
//   we, wa, wd    : write port, committed on the rising edge; r0 is never written
// A read of the register being written in the same cycle returns wd.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];
  logic        wr_live;

  assign wr_live = we && (wa != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wa] <= wd;
    end
  end

  // Write-first bypass; r0 is excluded by wr_live so it always reads zero.
  assign rd1 = (wr_live && wa == ra1) ? wd : (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (wr_live && wa == ra2) ? wd : (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode stage of the 5-stage pipeline.
//   clk, rst : clock, async active-high reset
//   bus      : id_stage_if.master (fetch inputs, writeback, hazard sources,
//              freeze / branch redirect and the registered ID/EX outputs)
// Holds the IF/ID and ID/EX registers, decode, load-use/RAW stall detection
// and branch resolution; the register file is the reg_file sub-module.
module id_stage
  import id_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  id_stage_if.master bus
);

  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] imm_sext;
  logic [31:0] rs_val, rt_val;
  ctrl_t       ctrl;
  logic        rs_hit, rt_hit, freeze, br_taken;

  assign rs       = ifid_instr[25:21];
  assign rt       = ifid_instr[20:16];
  assign imm      = ifid_instr[15:0];
  assign target   = ifid_instr[25:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign ctrl     = decode(ifid_instr);

  reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (bus.wb_en),
    .wa  (bus.wb_dest),
    .wd  (bus.wb_data)
  );

  // A source only stalls if the instruction actually reads it and an older
  // in-flight instruction will write it; r0 never creates a dependency.
  assign rs_hit = ctrl.use_rs && (rs != 5'd0) &&
                  ((bus.haz_ex_wb  && rs == bus.haz_ex_dest) ||
                   (bus.haz_mem_wb && rs == bus.haz_mem_dest));
  assign rt_hit = ctrl.use_rt && (rt != 5'd0) &&
                  ((bus.haz_ex_wb  && rt == bus.haz_ex_dest) ||
                   (bus.haz_mem_wb && rt == bus.haz_mem_dest));
  assign freeze = rs_hit || rt_hit;

  // Comparing stale operands would be wrong, so branches wait out the stall.
  assign br_taken = !freeze &&
                    ((ctrl.is_beq && rs_val == rt_val) ||
                     (ctrl.is_bne && rs_val != rt_val) ||
                     ctrl.is_j);

  assign bus.freeze   = freeze;
  assign bus.br_taken = br_taken;
  assign bus.br_addr  = ctrl.is_j ? {ifid_pc[31:28], target, 2'b00}
                                  : ifid_pc + {imm_sext[29:0], 2'b00};

  // IF/ID: a redirect squashes the wrong-path fetch even if a stall is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else if (br_taken) begin
      ifid_pc    <= bus.pc_inc_in;
      ifid_instr <= '0;
    end else if (!freeze) begin
      ifid_pc    <= bus.pc_inc_in;
      ifid_instr <= bus.instr_in;
    end
  end

  // ID/EX: operands always load; stalled or redirecting instructions leave as
  // a bubble with every control cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.idex_pc_inc  <= '0;
      bus.idex_val1    <= '0;
      bus.idex_val2    <= '0;
      bus.idex_imm     <= '0;
      bus.idex_dest    <= '0;
      bus.idex_alu_op  <= '0;
      bus.idex_alu_imm <= 1'b0;
      bus.idex_mem_rd  <= 1'b0;
      bus.idex_mem_wr  <= 1'b0;
      bus.idex_wb      <= 1'b0;
    end else begin
      bus.idex_pc_inc <= ifid_pc;
      bus.idex_val1   <= rs_val;
      bus.idex_val2   <= rt_val;
      bus.idex_imm    <= imm_sext;
      if (freeze || br_taken) begin
        bus.idex_dest    <= '0;
        bus.idex_alu_op  <= '0;
        bus.idex_alu_imm <= 1'b0;
        bus.idex_mem_rd  <= 1'b0;
        bus.idex_mem_wr  <= 1'b0;
        bus.idex_wb      <= 1'b0;
      end else begin
        bus.idex_dest    <= ctrl.dest;
        bus.idex_alu_op  <= ctrl.alu_op;
        bus.idex_alu_imm <= ctrl.alu_imm;
        bus.idex_mem_rd  <= ctrl.mem_rd;
        bus.idex_mem_wr  <= ctrl.mem_wr;
        bus.idex_wb      <= ctrl.wb;
      end
    end
  end

endmodule
